// File: rtl/application_selector_lcd_dfa_64_to_16.sv
// ---------------------------------------------------------------------------
// application_selector_lcd_dfa_64_to_16
//
// Avalon-ST data format adapter. It narrows the 64-bit LCD pixel stream that
// leaves the FIFO timing adapter into 16-bit beats for the pixel serializer.
// Each accepted input beat is held in one register and replayed slice by
// slice, with the MSB slice first. SOP/EOP/empty are re-expressed for the
// narrow bus. On an EOP beat only ceil(nvalid/OUT_SYMBOLS) slices are sent.
//
// Ports
//   clk, reset                 single clock, asynchronous active-high reset
//   in_ready/in_valid/in_data  sink handshake (zero ready latency), 64-bit data
//   in_startofpacket/in_endofpacket/in_empty   sink packet markers
//   out_ready/out_valid/out_data               source handshake, 16-bit data
//   out_startofpacket/out_endofpacket/out_empty source packet markers
//   pkt_error                  sticky framing error flag
//
// Configuration
//   LCD_DFA_PKT_CHECK_EN  When this is defined, the block tracks packet
//                         framing at input acceptance and raises pkt_error on
//                         the first framing violation. When it is undefined,
//                         pkt_error is tied low and no check logic exists.
// ---------------------------------------------------------------------------
module application_selector_lcd_dfa_64_to_16 #(
   parameter int SYMBOL_W    = 8,
   parameter int IN_SYMBOLS  = 8,
   parameter int OUT_SYMBOLS = 2,
   parameter int IN_EMPTY_W  = 3,
   parameter int OUT_EMPTY_W = 1
) (
   input  logic                            clk,
   input  logic                            reset,
   output logic                            in_ready,
   input  logic                            in_valid,
   input  logic [SYMBOL_W*IN_SYMBOLS-1:0]  in_data,
   input  logic                            in_startofpacket,
   input  logic                            in_endofpacket,
   input  logic [IN_EMPTY_W-1:0]           in_empty,
   input  logic                            out_ready,
   output logic                            out_valid,
   output logic [SYMBOL_W*OUT_SYMBOLS-1:0] out_data,
   output logic                            out_startofpacket,
   output logic                            out_endofpacket,
   output logic [OUT_EMPTY_W-1:0]          out_empty,
   output logic                            pkt_error
);

   localparam int IN_W       = SYMBOL_W * IN_SYMBOLS;
   localparam int OUT_W      = SYMBOL_W * OUT_SYMBOLS;
   localparam int NUM_SLICES = IN_SYMBOLS / OUT_SYMBOLS;
   localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
   // This width must hold IN_SYMBOLS + OUT_SYMBOLS - 1 for the ceiling division.
   localparam int CNT_W      = IN_EMPTY_W + 1;

   typedef enum logic {ST_EMPTY, ST_DRAIN} state_t;

   state_t                 state_q;
   logic [IDX_W-1:0]       idx_q;
   logic [IDX_W-1:0]       last_idx_q;
   logic [IN_W-1:0]        data_q;
   logic                   sop_q;
   logic                   eop_q;
   logic [OUT_EMPTY_W-1:0] empty_q;

   logic                   accept;
   logic                   out_xfer;
   logic                   at_last;
   logic [CNT_W-1:0]       nvalid;
   logic [CNT_W-1:0]       nslices;
   logic [IDX_W-1:0]       last_idx_d;
   logic [OUT_EMPTY_W-1:0] empty_d;

   assign at_last  = (idx_q == last_idx_q);
   // While draining, a new beat can be taken only when the final slice leaves
   // in the same cycle. This gives back-to-back beats with no bubble.
   assign in_ready = (state_q == ST_EMPTY) || (out_ready && at_last);
   assign accept   = in_valid && in_ready;
   assign out_xfer = (state_q == ST_DRAIN) && out_ready;

   // Slice count and narrow-bus empty for the beat being offered. The result
   // is evaluated once at acceptance and held, so the output flags need no
   // arithmetic.
   always_comb begin
      nvalid  = CNT_W'(IN_SYMBOLS) - {1'b0, in_empty};
      nslices = (nvalid + CNT_W'(OUT_SYMBOLS - 1)) / CNT_W'(OUT_SYMBOLS);
      if (in_endofpacket) begin
         last_idx_d = IDX_W'(nslices - 1'b1);
         empty_d    = OUT_EMPTY_W'(nslices * CNT_W'(OUT_SYMBOLS) - nvalid);
      end else begin
         last_idx_d = IDX_W'(NUM_SLICES - 1);
         empty_d    = '0;
      end
   end

   // NOTE: every sequential assignment is non-blocking. All registers then
   // sample pre-edge values, whatever order the statements are written in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the 64-bit holding register is reset too. out_data is
         // defined as zero out of reset, and this register feeds it directly.
         state_q    <= ST_EMPTY;
         idx_q      <= '0;
         last_idx_q <= '0;
         data_q     <= '0;
         sop_q      <= 1'b0;
         eop_q      <= 1'b0;
         empty_q    <= '0;
      end else if (accept) begin
         state_q    <= ST_DRAIN;
         idx_q      <= '0;
         last_idx_q <= last_idx_d;
         data_q     <= in_data;
         sop_q      <= in_startofpacket;
         eop_q      <= in_endofpacket;
         empty_q    <= empty_d;
      end else if (out_xfer) begin
         if (at_last) begin
            state_q <= ST_EMPTY;
            idx_q   <= '0;
         end else begin
            idx_q   <= idx_q + 1'b1;
         end
      end
   end

   // NOTE: give out_data a default before the loop. Without it, some idx
   // values would leave the signal unassigned and a latch would be inferred.
   always_comb begin
      out_data = '0;
      for (int s = 0; s < NUM_SLICES; s++) begin
         if (idx_q == IDX_W'(s)) out_data = data_q[IN_W-1-OUT_W*s -: OUT_W];
      end
   end

   assign out_valid         = (state_q == ST_DRAIN);
   assign out_startofpacket = out_valid && sop_q && (idx_q == '0);
   assign out_endofpacket   = out_valid && eop_q && at_last;
   assign out_empty         = (out_valid && eop_q && at_last) ? empty_q : '0;

`ifdef LCD_DFA_PKT_CHECK_EN
   logic in_pkt_q;
   logic err_q;
   logic frame_bad;

   assign frame_bad = (!in_pkt_q && !in_startofpacket)
                   || ( in_pkt_q &&  in_startofpacket)
                   || (!in_endofpacket && (in_empty != '0));

   // The check only observes accepted beats. It never stalls or changes the
   // data path.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_pkt_q <= 1'b0;
         err_q    <= 1'b0;
      end else if (accept) begin
         in_pkt_q <= !in_endofpacket;
         if (frame_bad) err_q <= 1'b1;
      end
   end

   assign pkt_error = err_q;
`else
   assign pkt_error = 1'b0;
`endif

endmodule

// File: tb/tb_application_selector_lcd_dfa_64_to_16.sv
module tb_application_selector_lcd_dfa_64_to_16;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_ready;
   logic        in_valid;
   logic [63:0] in_data;
   logic        in_startofpacket;
   logic        in_endofpacket;
   logic [2:0]  in_empty;
   logic        out_ready;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_startofpacket;
   logic        out_endofpacket;
   logic [0:0]  out_empty;
   logic        pkt_error;

   typedef struct packed {
      logic [15:0] data;
      logic        sop;
      logic        eop;
      logic        emp;
      logic        last;   // final slice of its input beat
   } beat_t;

   beat_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;
   int rdy_mode = 0;       // 0: out_ready held high, 1: toggles every cycle
   int cyc      = 0;
   int vcnt     = 0;
   int vfirst   = -1;
   int vlast    = -1;
   bit prev_stall = 1'b0;

   application_selector_lcd_dfa_64_to_16 dut (
      .clk               (clk),
      .reset             (reset),
      .in_ready          (in_ready),
      .in_valid          (in_valid),
      .in_data           (in_data),
      .in_startofpacket  (in_startofpacket),
      .in_endofpacket    (in_endofpacket),
      .in_empty          (in_empty),
      .out_ready         (out_ready),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_startofpacket (out_startofpacket),
      .out_endofpacket   (out_endofpacket),
      .out_empty         (out_empty),
      .pkt_error         (pkt_error)
   );

   always #5 clk = ~clk;

   // out_ready driver, updated just after each rising edge.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 1) out_ready = ~out_ready;
         else               out_ready = 1'b1;
      end
   end

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      beat_t exp;
      cyc++;
      if (!reset) begin
         if (prev_stall) begin
            n_checks++;
            if (out_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL stall_hold: out_valid=%b required 1", out_valid);
            end
         end
         if (out_valid === 1'b1) begin
            vcnt++;
            if (vfirst < 0) vfirst = cyc;
            vlast = cyc;
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_beat: data=%h with empty scoreboard", out_data);
            end else begin
               exp = sb[0];
               if ({out_data, out_startofpacket, out_endofpacket, out_empty} !==
                   {exp.data, exp.sop, exp.eop, exp.emp}) begin
                  n_fail++;
                  $display("FAIL out_beat: data=%h sop=%b eop=%b empty=%b required data=%h sop=%b eop=%b empty=%b",
                           out_data, out_startofpacket, out_endofpacket, out_empty,
                           exp.data, exp.sop, exp.eop, exp.emp);
               end
               n_checks++;
               if (in_ready !== (out_ready && exp.last)) begin
                  n_fail++;
                  $display("FAIL in_ready_drain: in_ready=%b required %b", in_ready, out_ready && exp.last);
               end
               if (out_ready) void'(sb.pop_front());
            end
         end else begin
            n_checks++;
            if (in_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL in_ready_idle: in_ready=%b required 1", in_ready);
            end
         end
`ifndef LCD_DFA_PKT_CHECK_EN
         n_checks++;
         if (pkt_error !== 1'b0) begin
            n_fail++;
            $display("FAIL pkt_error_off: pkt_error=%b required 0", pkt_error);
         end
`endif
         prev_stall = (out_valid === 1'b1) && !out_ready;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Drives one input beat, pushes its expected slices and returns just after
   // the edge that accepts it.
   task automatic send_beat(input logic [63:0] d, input logic s, input logic e,
                            input logic [2:0] emp);
      int nvalid, ns, waited;
      beat_t b;
      in_valid = 1'b1; in_data = d; in_startofpacket = s;
      in_endofpacket = e; in_empty = emp;
      waited = 0;
      forever begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            nvalid = e ? 8 - int'(emp) : 8;
            ns     = (nvalid + 1) / 2;
            for (int k = 0; k < ns; k++) begin
               b.data = d[63-16*k -: 16];
               b.sop  = s && (k == 0);
               b.eop  = e && (k == ns - 1);
               b.emp  = e && (k == ns - 1) && (nvalid % 2 == 1);
               b.last = (k == ns - 1);
               sb.push_back(b);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
         end
         waited++;
         if (waited > 100) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: in_ready=%b required 1 within 100 cycles", in_ready);
            in_valid = 1'b0;
            return;
         end
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: %0d beats outstanding required 0", sb.size());
         sb.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_data, out_startofpacket, out_endofpacket, out_empty, pkt_error, in_ready} !==
          {1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_state: valid=%b data=%h sop=%b eop=%b empty=%b err=%b rdy=%b required 0 0000 0 0 0 0 1",
                  out_valid, out_data, out_startofpacket, out_endofpacket, out_empty, pkt_error, in_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_full_beat();
      rdy_mode = 0;
      send_beat(64'h0011223344556677, 1'b1, 1'b1, 3'd0);
      wait_drain();
   endtask

   task automatic test_empty_eop();
      send_beat(64'h0011223344556677, 1'b1, 1'b1, 3'd3);
      wait_drain();
      send_beat(64'hA1B2C3D4E5F60718, 1'b1, 1'b1, 3'd7);
      wait_drain();
      send_beat(64'h1357_9BDF_2468_ACE0, 1'b1, 1'b1, 3'd2);
      wait_drain();
   endtask

   task automatic test_back_to_back();
      rdy_mode = 0;
      vcnt = 0; vfirst = -1; vlast = -1;
      send_beat({$urandom, $urandom}, 1'b1, 1'b0, 3'd0);
      send_beat({$urandom, $urandom}, 1'b0, 1'b0, 3'd0);
      send_beat({$urandom, $urandom}, 1'b0, 1'b1, 3'd1);
      wait_drain();
      n_checks++;
      if (vcnt != 12 || (vlast - vfirst) != 11) begin
         n_fail++;
         $display("FAIL back_to_back: valid_cycles=%0d span=%0d required 12 and 11", vcnt, vlast - vfirst);
      end
   endtask

   task automatic test_stall();
      rdy_mode = 1;
      send_beat(64'h0011223344556677, 1'b1, 1'b0, 3'd0);
      send_beat(64'h8899AABBCCDDEEFF, 1'b0, 1'b1, 3'd0);
      wait_drain();
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      rdy_mode = 0;
      send_beat(64'hDEADBEEFCAFEF00D, 1'b1, 1'b1, 3'd0);
      @(posedge clk);          // slice 0 leaves
      @(posedge clk);          // slice 1 leaves
      #1;
      reset = 1'b1;
      sb.delete();
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_mid: valid=%b data=%h required 0 0000", out_valid, out_data);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: valid=%b required 0", out_valid);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_pkt_check();
      logic exp_err;
`ifdef LCD_DFA_PKT_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      apply_reset();
      send_beat(64'h0102030405060708, 1'b0, 1'b1, 3'd0);
      wait_drain();
      n_checks++;
      if (pkt_error !== exp_err) begin
         n_fail++;
         $display("FAIL pkt_error_set: pkt_error=%b required %b", pkt_error, exp_err);
      end
      send_beat(64'h1112131415161718, 1'b1, 1'b1, 3'd0);
      wait_drain();
      n_checks++;
      if (pkt_error !== exp_err) begin
         n_fail++;
         $display("FAIL pkt_error_sticky: pkt_error=%b required %b", pkt_error, exp_err);
      end
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0; in_data = '0; in_startofpacket = 1'b0;
      in_endofpacket = 1'b0; in_empty = '0;
      test_reset();
      test_full_beat();
      test_empty_eop();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_full_beat();
      test_pkt_check();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
